// File: rtl/yj_async_handshake_rx_pkg.sv
// rtl/yj_async_handshake_rx_pkg.sv - shared types and defaults for the PS->PL handshake receiver
//
// Purpose: FSM state encoding and parameter defaults shared by the receiver files.
// Ports:   none (package).

package yj_async_handshake_rx_pkg;

    // Receiver FSM states; encodings are fixed so they are recognisable in debug dumps.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int TO_CYC_DEFAULT = 1023;

    // Timeout counter width covers the largest legal TO_CYC (65535).
    localparam int TO_CW = 16;

endpackage

// File: rtl/yj_basic_signal_2lever_sync.sv
// rtl/yj_basic_signal_2lever_sync.sv - two-flop level synchroniser
//
// Purpose: brings a level signal that is asynchronous to CLK into the CLK domain.
// Ports:
//   CLK  - destination clock
//   RSTn - asynchronous active-low reset, clears both flops
//   d_i  - asynchronous input level
//   q_o  - synchronised level, two CLK edges behind d_i

module yj_basic_signal_2lever_sync #(
    parameter int DW = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] meta_q;
    logic [DW-1:0] sync_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/yj_async_handshake_rx.sv
// rtl/yj_async_handshake_rx.sv - four-phase req/ack receiver from the PS into the PL clock domain
//
// Purpose: synchronises ext_req, captures ext_data once req is seen, offers the word on a
//          valid/ready interface, then completes the req/ack handshake, with a sticky
//          stuck-handshake timeout and a completed-transfer counter.
// Ports:
//   CLK, RSTn    - clock, asynchronous active-low reset
//   ext_req      - async request from the PS
//   ext_data     - async data from the PS, stable while ext_req is high and unacknowledged
//   ext_ack      - registered acknowledge back to the PS
//   dout         - captured word
//   dout_valid   - dout holds an unconsumed word
//   dout_ready   - downstream accepts dout when dout_valid is high
//   err_timeout  - sticky flag: PS held ext_req high TO_CYC cycles after ack
//   err_clr      - synchronous clear of err_timeout (a simultaneous set wins)
//   xfer_cnt     - completed-transfer count, wraps

module yj_async_handshake_rx
    import yj_async_handshake_rx_pkg::*;
#(
    parameter int DW     = 32,
    parameter int TO_CYC = TO_CYC_DEFAULT,
    parameter int CW     = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          ext_req,
    input  logic [DW-1:0] ext_data,
    output logic          ext_ack,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          err_timeout,
    input  logic          err_clr,
    output logic [CW-1:0] xfer_cnt
);

    localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_CYC - 1);

    logic             req_s;
    state_t           state_q;
    logic             ack_q;
    logic [DW-1:0]    dout_q;
    logic             valid_q;
    logic             err_q;
    logic [CW-1:0]    xfer_q;
    logic [TO_CW-1:0] to_cnt_q;
    logic [TO_CW-1:0] to_cnt_d;

    yj_basic_signal_2lever_sync #(
        .DW (1)
    ) u_req_sync (
        .CLK  (CLK),
        .RSTn (RSTn),
        .d_i  (ext_req),
        .q_o  (req_s)
    );

    // Saturate at all-ones so the equality with TO_LAST fires exactly once per stuck
    // handshake; a cleared flag is not re-raised while the PS stays stuck.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            xfer_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            // Clear first; a set in the ACK branch below overrides it on the same edge.
            if (err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // ext_data is safe to sample here: the PS holds it stable from before
                    // ext_req rises until it sees ack, and req_s lags ext_req by two edges.
                    if (req_s) begin
                        dout_q  <= ext_data;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end
                end

                VALID: begin
                    // req_s is deliberately ignored here: a word already captured is
                    // always delivered, even if the PS withdraws req early.
                    if (dout_ready) begin
                        valid_q  <= 1'b0;
                        ack_q    <= 1'b1;
                        xfer_q   <= xfer_q + 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ACK;
                    end
                end

                ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_cnt_q == TO_LAST) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ext_ack     = ack_q;
    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign err_timeout = err_q;
    assign xfer_cnt    = xfer_q;

endmodule
